// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the unified memory and mem_arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              dataReq;
  logic              dataWr;
  logic [ADDR_W-1:0] dataAddr;
  logic [DATA_W-1:0] dataWrData;
  logic [DATA_W-1:0] memRdData;
  logic              memEn;
  logic              memWr;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWrData;
  logic [DATA_W-1:0] ifData;
  logic              ifDone;
  logic [DATA_W-1:0] dataRdData;
  logic              dataDone;
  logic              ifStall;
  logic              memStall;

  modport slave (
    input  ifReq, ifAddr, dataReq, dataWr, dataAddr, dataWrData, memRdData,
    output memEn, memWr, memAddr, memWrData, ifData, ifDone, dataRdData, dataDone,
           ifStall, memStall
  );

  modport master (
    output ifReq, ifAddr, dataReq, dataWr, dataAddr, dataWrData, memRdData,
    input  memEn, memWr, memAddr, memWrData, ifData, ifDone, dataRdData, dataDone,
           ifStall, memStall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory port between fetch and the MEM stage; data wins
// arbitration except when a fetch was kept waiting through the previous data access.
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_D = 2'd1;
  localparam logic [1:0] BUSY_F = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              fair_q, fair_d;
  logic              seen_q, seen_d;
  logic              sel_data_q, sel_data_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              grant_f, grant_d, busy;

  assign grant_f = bus.ifReq & (fair_q | ~bus.dataReq);
  assign grant_d = bus.dataReq & ~(fair_q & bus.ifReq);
  assign busy    = (state_q == BUSY_D) || (state_q == BUSY_F);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fair_d     = fair_q;
    seen_d     = seen_q;
    sel_data_d = sel_data_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_data_d  = if_data_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (grant_f) begin
          state_d    = BUSY_F;
          addr_d     = bus.ifAddr;
          wdata_d    = '0;
          wr_d       = 1'b0;
          sel_data_d = 1'b0;
          fair_d     = 1'b0;
          cnt_d      = CNT_INIT;
        end else if (grant_d) begin
          state_d    = BUSY_D;
          addr_d     = bus.dataAddr;
          wdata_d    = bus.dataWrData;
          wr_d       = bus.dataWr;
          sel_data_d = 1'b1;
          seen_d     = bus.ifReq;
          cnt_d      = CNT_INIT;
        end
      end
      BUSY_D, BUSY_F: begin
        // Track whether fetch was waiting at any point of this data access
        if (state_q == BUSY_D) begin
          seen_d = seen_q | bus.ifReq;
        end
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (state_q == BUSY_F) begin
            if_data_d = bus.memRdData;
          end else begin
            if (!wr_q) begin
              rd_data_d = bus.memRdData;
            end
            fair_d = seen_q | bus.ifReq;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fair_q     <= 1'b0;
      seen_q     <= 1'b0;
      sel_data_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fair_q     <= fair_d;
      seen_q     <= seen_d;
      sel_data_q <= sel_data_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.memEn      = busy;
  assign bus.memWr      = (state_q == BUSY_D) & wr_q;
  assign bus.memAddr    = busy ? addr_q : '0;
  assign bus.memWrData  = (state_q == BUSY_D) ? wdata_q : '0;
  assign bus.ifData     = if_data_q;
  assign bus.dataRdData = rd_data_q;
  assign bus.ifDone     = (state_q == DONE) & ~sel_data_q;
  assign bus.dataDone   = (state_q == DONE) & sel_data_q;
  // Stalls drop in the done cycle so the pipeline register advances on that edge
  assign bus.ifStall    = bus.ifReq & ~bus.ifDone;
  assign bus.memStall   = bus.dataReq & ~bus.dataDone;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=4 instance for most steps, LATENCY=1 for the short case.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b4 ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();

  mem_arbiter #(.LATENCY(4), .ADDR_W(16), .DATA_W(16)) u4 (.clk(clk), .rst(rst), .bus(b4));
  mem_arbiter #(.LATENCY(1), .ADDR_W(16), .DATA_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    b4.ifReq = 0; b4.ifAddr = 0; b4.dataReq = 0; b4.dataWr = 0;
    b4.dataAddr = 0; b4.dataWrData = 0; b4.memRdData = 0;
    b1.ifReq = 0; b1.ifAddr = 0; b1.dataReq = 0; b1.dataWr = 0;
    b1.dataAddr = 0; b1.dataWrData = 0; b1.memRdData = 0;

    // Reset state
    nxt(); nxt();
    smp();
    chk("rst_memEn", 32'(b4.memEn), 32'd0);
    chk("rst_memAddr", 32'(b4.memAddr), 32'd0);
    chk("rst_ifData", 32'(b4.ifData), 32'd0);
    chk("rst_dataRd", 32'(b4.dataRdData), 32'd0);
    chk("rst_dones", {30'd0, b4.ifDone, b4.dataDone}, 32'd0);
    nxt(); rst = 1'b1;
    nxt();

    // 1: fetch
    nxt(); b4.ifReq = 1; b4.ifAddr = 16'h0010; b4.memRdData = 16'hDEAD;
    smp();
    chk("t1_c0_ifStall", 32'(b4.ifStall), 32'd1);
    chk("t1_c0_memEn", 32'(b4.memEn), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      nxt();
      b4.memRdData = (k == 4) ? 16'hA5A5 : 16'hDEAD;
      smp();
      chk($sformatf("t1_c%0d_memEn", k), 32'(b4.memEn), (k <= 4) ? 32'd1 : 32'd0);
      if (k <= 4) chk($sformatf("t1_c%0d_memAddr", k), 32'(b4.memAddr), 32'h0010);
      chk($sformatf("t1_c%0d_ifDone", k), 32'(b4.ifDone), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("t1_c%0d_ifStall", k), 32'(b4.ifStall), (k < 5) ? 32'd1 : 32'd0);
    end
    chk("t1_ifData", 32'(b4.ifData), 32'hA5A5);
    nxt(); b4.ifReq = 0;
    smp();
    chk("t1_c6_memEn", 32'(b4.memEn), 32'd0);

    // 2: store; input changes after grant must not leak through
    nxt(); b4.dataReq = 1; b4.dataWr = 1; b4.dataAddr = 16'h0200; b4.dataWrData = 16'h1234;
    b4.memRdData = 16'hBEEF;
    smp();
    for (int k = 1; k <= 5; k++) begin
      nxt();
      b4.dataAddr = 16'h0999; b4.dataWrData = 16'h9999;
      smp();
      chk($sformatf("t2_c%0d_memWr", k), 32'(b4.memWr), (k <= 4) ? 32'd1 : 32'd0);
      if (k <= 4) begin
        chk($sformatf("t2_c%0d_memWrData", k), 32'(b4.memWrData), 32'h1234);
        chk($sformatf("t2_c%0d_memAddr", k), 32'(b4.memAddr), 32'h0200);
      end
      chk($sformatf("t2_c%0d_dataDone", k), 32'(b4.dataDone), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("t2_c%0d_memStall", k), 32'(b4.memStall), (k < 5) ? 32'd1 : 32'd0);
    end
    chk("t2_dataRd_unchanged", 32'(b4.dataRdData), 32'd0);
    nxt(); b4.dataReq = 0; b4.dataWr = 0;

    // 3: simultaneous requests, data first, then fairness lets fetch win
    nxt(); b4.ifReq = 1; b4.ifAddr = 16'h0040;
    b4.dataReq = 1; b4.dataWr = 0; b4.dataAddr = 16'h0300; b4.memRdData = 16'h0000;
    smp();
    for (int k = 1; k <= 5; k++) begin
      nxt();
      b4.memRdData = (k == 4) ? 16'h5A5A : 16'h0000;
      smp();
      if (k <= 4) chk($sformatf("t3_c%0d_memAddr", k), 32'(b4.memAddr), 32'h0300);
      chk($sformatf("t3_c%0d_dataDone", k), 32'(b4.dataDone), (k == 5) ? 32'd1 : 32'd0);
    end
    chk("t3_dataRd", 32'(b4.dataRdData), 32'h5A5A);
    chk("t3_c5_ifStall", 32'(b4.ifStall), 32'd1);
    nxt(); b4.dataAddr = 16'h0400;
    smp();
    chk("t3_c6_memEn", 32'(b4.memEn), 32'd0);
    for (int k = 7; k <= 11; k++) begin
      nxt();
      b4.memRdData = (k == 10) ? 16'h1111 : 16'h0000;
      smp();
      if (k <= 10) chk($sformatf("t3_c%0d_memAddr", k), 32'(b4.memAddr), 32'h0040);
      chk($sformatf("t3_c%0d_ifDone", k), 32'(b4.ifDone), (k == 11) ? 32'd1 : 32'd0);
      chk($sformatf("t3_c%0d_memStall", k), 32'(b4.memStall), 32'd1);
    end
    chk("t3_ifData", 32'(b4.ifData), 32'h1111);
    nxt(); b4.ifReq = 0;
    smp();
    chk("t3_c12_memEn", 32'(b4.memEn), 32'd0);
    for (int k = 13; k <= 17; k++) begin
      nxt();
      b4.memRdData = (k == 16) ? 16'h2222 : 16'h0000;
      smp();
      if (k <= 16) chk($sformatf("t3_c%0d_memAddr", k), 32'(b4.memAddr), 32'h0400);
      chk($sformatf("t3_c%0d_dataDone", k), 32'(b4.dataDone), (k == 17) ? 32'd1 : 32'd0);
    end
    chk("t3_dataRd2", 32'(b4.dataRdData), 32'h2222);
    nxt(); b4.dataReq = 0;

    // 4: fetch squashed mid-access
    nxt(); b4.ifReq = 1; b4.ifAddr = 16'h0080;
    smp();
    for (int k = 1; k <= 6; k++) begin
      nxt();
      if (k == 2) b4.ifReq = 0;
      b4.memRdData = (k == 4) ? 16'h7777 : 16'h0000;
      smp();
      chk($sformatf("t4_c%0d_memEn", k), 32'(b4.memEn), (k <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("t4_c%0d_ifDone", k), 32'(b4.ifDone), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("t4_c%0d_ifStall", k), 32'(b4.ifStall), (k < 2) ? 32'd1 : 32'd0);
    end
    chk("t4_ifData", 32'(b4.ifData), 32'h7777);

    // 5: asynchronous reset during a store
    nxt(); b4.dataReq = 1; b4.dataWr = 1; b4.dataAddr = 16'h0500; b4.dataWrData = 16'hCAFE;
    nxt(); nxt(); nxt();
    smp();
    chk("t5_c3_memWr", 32'(b4.memWr), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_memEn", 32'(b4.memEn), 32'd0);
    chk("t5_rst_memWr", 32'(b4.memWr), 32'd0);
    chk("t5_rst_memAddr", 32'(b4.memAddr), 32'd0);
    chk("t5_rst_memWrData", 32'(b4.memWrData), 32'd0);
    chk("t5_rst_ifData", 32'(b4.ifData), 32'd0);
    chk("t5_rst_dataRd", 32'(b4.dataRdData), 32'd0);
    chk("t5_rst_dataDone", 32'(b4.dataDone), 32'd0);
    nxt();
    chk("t5_hold_memEn", 32'(b4.memEn), 32'd0);
    chk("t5_hold_dataDone", 32'(b4.dataDone), 32'd0);
    rst = 1'b1;
    smp();
    chk("t5_rel_memEn", 32'(b4.memEn), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      nxt();
      smp();
      chk($sformatf("t5_r%0d_memEn", k), 32'(b4.memEn), (k <= 4) ? 32'd1 : 32'd0);
      if (k <= 4) chk($sformatf("t5_r%0d_memAddr", k), 32'(b4.memAddr), 32'h0500);
      chk($sformatf("t5_r%0d_dataDone", k), 32'(b4.dataDone), (k == 5) ? 32'd1 : 32'd0);
    end
    nxt(); b4.dataReq = 0; b4.dataWr = 0;

    // 6: LATENCY=1 back-to-back loads
    nxt(); b1.dataReq = 1; b1.dataWr = 0; b1.dataAddr = 16'h0600; b1.memRdData = 16'h3C3C;
    smp();
    chk("t6_c0_memStall", 32'(b1.memStall), 32'd1);
    chk("t6_c0_memEn", 32'(b1.memEn), 32'd0);
    nxt();
    smp();
    chk("t6_c1_memEn", 32'(b1.memEn), 32'd1);
    chk("t6_c1_memAddr", 32'(b1.memAddr), 32'h0600);
    nxt(); b1.dataAddr = 16'h0700; b1.memRdData = 16'h4D4D;
    smp();
    chk("t6_c2_memEn", 32'(b1.memEn), 32'd0);
    chk("t6_c2_dataDone", 32'(b1.dataDone), 32'd1);
    chk("t6_c2_memStall", 32'(b1.memStall), 32'd0);
    chk("t6_c2_dataRd", 32'(b1.dataRdData), 32'h3C3C);
    nxt();
    smp();
    chk("t6_c3_memEn", 32'(b1.memEn), 32'd0);
    nxt();
    smp();
    chk("t6_c4_memEn", 32'(b1.memEn), 32'd1);
    chk("t6_c4_memAddr", 32'(b1.memAddr), 32'h0700);
    nxt();
    smp();
    chk("t6_c5_dataDone", 32'(b1.dataDone), 32'd1);
    chk("t6_c5_dataRd", 32'(b1.dataRdData), 32'h4D4D);
    nxt(); b1.dataReq = 0;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-ported, multi-cycle unified memory between the fetch stage (IF) and the memory stage (MEM).
- Generates the `ifStall` and `memStall` signals that freeze the IF/ID and MEM/WB pipeline registers while an access is outstanding.
- MEM requests normally win arbitration. A one-shot fairness flag keeps fetch from starving behind back-to-back data accesses.

Parameters:
- LATENCY, 4, memory cycles per access; legal range 1..15; memory read data is valid on the last busy cycle.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- ifReq  input  1  fetch request; held until ifDone
- ifAddr  input  ADDR_W  fetch address
- dataReq  input  1  MEM-stage request (load or store); held until dataDone
- dataWr  input  1  1=store, 0=load; qualifies dataReq
- dataAddr  input  ADDR_W  data address
- dataWrData  input  DATA_W  store data
- memRdData  input  DATA_W  read data from memory
- memEn  output  1  memory enable, high for every busy cycle
- memWr  output  1  memory write strobe, high for every busy cycle of a store
- memAddr  output  ADDR_W  address to memory
- memWrData  output  DATA_W  write data to memory
- ifData  output  DATA_W  fetched instruction, registered
- ifDone  output  1  one-cycle fetch completion pulse
- dataRdData  output  DATA_W  load data, registered
- dataDone  output  1  one-cycle data completion pulse
- ifStall  output  1  `ifReq & ~ifDone`
- memStall  output  1  `dataReq & ~dataDone`

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE, counter=0, fairness flag=0.
  - memEn, memWr, memAddr, memWrData, ifData, dataRdData, ifDone and dataDone all 0.
  - Reset mid-access abandons the access with no done pulse.
- States: IDLE, BUSY_D, BUSY_F, DONE.
- IDLE arbitration, evaluated each cycle:
  - fairFlag=1 and ifReq → BUSY_F, then clear fairFlag.
  - Otherwise dataReq → BUSY_D.
  - Otherwise ifReq → BUSY_F.
  - Otherwise stay in IDLE.
  - On grant, latch the address, write data and dataWr into internal registers. Load counter with LATENCY-1.
- BUSY_x:
  - memEn=1; memAddr and memWrData come from the latched registers; memWr = latched dataWr (BUSY_D only).
  - Counter decrements each cycle.
  - When counter==0: capture memRdData into ifData (BUSY_F) or dataRdData (BUSY_D loads only; stores leave it unchanged), then → DONE.
- DONE:
  - Exactly one cycle. The matching done output is 1, memEn=0.
  - No grant is made in DONE, because the completing requester's req is still high that cycle. → IDLE.
- Fairness flag:
  - Set on entering DONE from BUSY_D if ifReq was high at any cycle during that access; otherwise cleared.
  - Cleared on any fetch grant.
- Latency: request high in IDLE at cycle t:
  - busy t+1..t+LATENCY;
  - done pulse at t+LATENCY+1;
  - next grant possible at t+LATENCY+2.
- Stall outputs:
  - Purely combinational from req and done.
  - memStall falls in the done cycle so MEM/WB advances on that edge.
- Request dropped mid-access (e.g. fetch squashed by a branch):
  - The access runs to completion and the done pulse still fires; the requester ignores it.
  - Memory side effects of a store are never aborted.
- Requests arriving while BUSY or in DONE wait in IDLE.
- Address or data changes on the inputs during BUSY have no effect; the latched values are used.
- dataWr is ignored unless dataReq is high.

Test Plan:
1. Reset, then ifReq=1, ifAddr=0x0010, memRdData=0xA5A5 on the last busy cycle (LATENCY=4), request at cycle 0 → memEn high cycles 1-4 with memAddr=0x0010, ifDone=1 and ifData=0xA5A5 at cycle 5, ifStall high cycles 0-4.
2. Store: dataReq=1, dataWr=1, dataAddr=0x0200, dataWrData=0x1234 → memWr=1 cycles 1-4, memWrData=0x1234, dataDone at 5, dataRdData unchanged.
3. ifReq and dataReq both raised at cycle 0, load from 0x0300 → data is granted first with done at 5. Fetch is granted at cycle 6 and ifDone fires at 11. A new dataReq at cycle 6 waits; fairFlag=1 lets fetch win.
4. Fetch request dropped at cycle 2 of a BUSY_F → access continues; ifDone still pulses at 5 and ifStall stays 0 after cycle 2.
5. Assert rst=0 asynchronously mid-BUSY_D (cycle 3) → all outputs 0 immediately, state IDLE, no dataDone. After release with dataReq held, a new access starts on the first edge.
6. LATENCY=1: dataReq at cycle 0 → memEn high only at cycle 1, dataDone at cycle 2, next grant possible at cycle 3.
